// File: rtl/sphere_table.sv
// Indexed scene-object store: per-entry sphere registers with an active mask,
// and a scan engine that streams active entries in index order over valid/ready.
module sphere_table #(
  parameter  int NUM_SPHERES = 8,
  parameter  int COORD_W     = 32,
  parameter  int COLOR_W     = 8,
  localparam int IDX_W       = (NUM_SPHERES > 1) ? $clog2(NUM_SPHERES) : 1,
  localparam int CNT_W       = $clog2(NUM_SPHERES + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_en_i,
  input  logic [IDX_W-1:0]     wr_idx_i,
  input  logic                 wr_active_i,
  input  logic [3*COORD_W-1:0] wr_pos_i,
  input  logic [COORD_W-1:0]   wr_radius_i,
  input  logic [3*COLOR_W-1:0] wr_col_i,
  input  logic                 scan_start_i,
  output logic                 scan_busy_o,
  output logic                 scan_done_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [IDX_W-1:0]     out_idx_o,
  output logic [3*COORD_W-1:0] out_pos_o,
  output logic [COORD_W-1:0]   out_radius_o,
  output logic [3*COLOR_W-1:0] out_col_o,
  output logic                 out_last_o,
  output logic [CNT_W-1:0]     active_count_o
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_e;

  logic [NUM_SPHERES-1:0] act_q;
  logic [3*COORD_W-1:0]   pos_q [NUM_SPHERES];
  logic [COORD_W-1:0]     rad_q [NUM_SPHERES];
  logic [3*COLOR_W-1:0]   col_q [NUM_SPHERES];
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  state_e                 state_q;
  logic [IDX_W-1:0]       ptr_q, hi_idx;
  logic [NUM_SPHERES-1:0] mask_q;
  logic                   busy_q, done_q, valid_q, last_q;
  logic [IDX_W-1:0]       idx_q;
  logic [3*COORD_W-1:0]   opos_q;
  logic [COORD_W-1:0]     orad_q;
  logic [3*COLOR_W-1:0]   ocol_q;

  logic wr_ok, slot_free, ptr_end;

  // Out-of-range indices are dropped; reset takes priority over a write.
  assign wr_ok     = wr_en_i && !rst_i && ({1'b0, wr_idx_i} < NUM_SPHERES[IDX_W:0]);
  assign slot_free = !valid_q || out_ready_i;
  assign ptr_end   = (ptr_q == IDX_W'(NUM_SPHERES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i)      act_q <= '0;
    else if (wr_ok) act_q[wr_idx_i] <= wr_active_i;
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      pos_q[wr_idx_i] <= wr_pos_i;
      rad_q[wr_idx_i] <= wr_radius_i;
      col_q[wr_idx_i] <= wr_col_i;
    end
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NUM_SPHERES; i++) cnt_d = cnt_d + CNT_W'(act_q[i]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Highest active index of the snapshot marks the final beat.
  always_comb begin
    hi_idx = '0;
    for (int i = 0; i < NUM_SPHERES; i++) if (mask_q[i]) hi_idx = IDX_W'(i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      mask_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      opos_q  <= '0;
      orad_q  <= '0;
      ocol_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (valid_q && out_ready_i) valid_q <= 1'b0;
      case (state_q)
        IDLE: if (scan_start_i) begin
          mask_q  <= act_q;
          ptr_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= SCAN;
        end
        SCAN: if (slot_free) begin
          if (mask_q[ptr_q]) begin
            valid_q <= 1'b1;
            idx_q   <= ptr_q;
            opos_q  <= pos_q[ptr_q];
            orad_q  <= rad_q[ptr_q];
            ocol_q  <= col_q[ptr_q];
            last_q  <= (ptr_q == hi_idx);
          end
          if (ptr_end) state_q <= DRAIN;
          else         ptr_q   <= ptr_q + 1'b1;
        end
        DRAIN: if (slot_free) begin
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign scan_busy_o    = busy_q;
  assign scan_done_o    = done_q;
  assign out_valid_o    = valid_q;
  assign out_idx_o      = idx_q;
  assign out_pos_o      = opos_q;
  assign out_radius_o   = orad_q;
  assign out_col_o      = ocol_q;
  assign out_last_o     = last_q;
  assign active_count_o = cnt_q;

endmodule
